// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and Gray/binary helpers for the async FIFO pointer blocks.
`default_nettype none

package fifo_pkg;

    localparam int DEFAULT_ADDRSIZE = 8;
    localparam int SYNC_STAGES_MIN  = 2;
    localparam int PTR_MAX_W        = 32;

    // Callers zero-extend narrower pointers and truncate the result.
    // Leading zeros do not change the low bits of either conversion.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return (b >> 1) ^ b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rptr_empty_flags_if.sv
// rptr_empty_flags_if: read-side pointer/flag bundle between the FIFO read domain and its user.
`default_nettype none

interface rptr_empty_flags_if
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = DEFAULT_ADDRSIZE
) ();

    logic [ADDRSIZE:0]   wptr;
    logic                rinc;
    logic                rflush;
    logic                rclr_err;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                ralmost_empty;
    logic [ADDRSIZE:0]   rcount;
    logic                runderflow;

    modport master (
        output wptr, rinc, rflush, rclr_err,
        input  raddr, rptr, rempty, ralmost_empty, rcount, runderflow
    );

    modport slave (
        input  wptr, rinc, rflush, rclr_err,
        output raddr, rptr, rempty, ralmost_empty, rcount, runderflow
    );

endinterface

`default_nettype wire

// File: rtl/sync_w2r_n.sv
// sync_w2r_n: STAGES-deep flop chain carrying a Gray pointer into another clock domain.
`default_nettype none

module sync_w2r_n
    import fifo_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_ADDRSIZE + 1,
    parameter int STAGES = SYNC_STAGES_MIN
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rptr_empty_flags.sv
// rptr_empty_flags: read-domain pointer, empty/almost-empty/occupancy flags, sticky underflow and flush.
// A flush moves rptr by more than one Gray bit; the write side must accept that jump.
`default_nettype none

module rptr_empty_flags
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE    = DEFAULT_ADDRSIZE,
    parameter int AE_LEVEL    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          rclk,
    input  wire logic          rrst_n,
    rptr_empty_flags_if.slave  bus
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] rq2_wptr;
    logic [PW-1:0] rq2_wbin;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] cnt_next;
    logic [PW-1:0] rcount;
    logic          rempty;
    logic          ralmost_empty;
    logic          runderflow;
    logic          rd;
    logic          underflow_set;

    sync_w2r_n #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_w2r (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (bus.wptr),
        .q     (rq2_wptr)
    );

    assign rq2_wbin = PW'(gray2bin(PTR_MAX_W'(rq2_wptr)));

    // Flush overrides both reads and underflow detection.
    assign rd            = bus.rinc & ~rempty & ~bus.rflush;
    assign underflow_set = bus.rinc & rempty & ~bus.rflush;

    assign rbinnext  = bus.rflush ? rq2_wbin : rbin + {{ADDRSIZE{1'b0}}, rd};
    assign rgraynext = PW'(bin2gray(PTR_MAX_W'(rbinnext)));
    assign cnt_next  = rq2_wbin - rbinnext;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin          <= '0;
            rptr          <= '0;
            rcount        <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            runderflow    <= 1'b0;
        end else begin
            rbin          <= rbinnext;
            rptr          <= rgraynext;
            rcount        <= cnt_next;
            rempty        <= (rgraynext == rq2_wptr);
            ralmost_empty <= (cnt_next <= PW'(AE_LEVEL));
            if (underflow_set) begin
                runderflow <= 1'b1;
            end else if (bus.rclr_err) begin
                runderflow <= 1'b0;
            end
        end
    end

    assign bus.raddr         = rbin[ADDRSIZE-1:0];
    assign bus.rptr          = rptr;
    assign bus.rempty        = rempty;
    assign bus.ralmost_empty = ralmost_empty;
    assign bus.rcount        = rcount;
    assign bus.runderflow    = runderflow;

endmodule

`default_nettype wire

// File: doc/rptr_empty_flags.md
Name: rptr_empty_flags

Overview:
Next-generation read-side pointer and flag block for the async FIFO, running in the read clock domain. It contains its own parametrised write-pointer synchronizer, a binary/Gray read pointer, and registered empty, almost-empty, occupancy and underflow outputs. It also provides a read-side flush. It drives the SRAM read address and returns the Gray read pointer to the write domain.

Parameters:
ADDRSIZE, 8, address width; FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits
AE_LEVEL, 4, almost-empty threshold in words; legal range 0..2**ADDRSIZE
SYNC_STAGES, 2, flop stages in the write-pointer synchronizer; minimum 2

Ports:
rclk  input  1  read clock; all logic on rising edge
rrst_n  input  1  synchronous active-low reset
wptr  input  ADDRSIZE+1  Gray write pointer from write domain (asynchronous)
rinc  input  1  read request
rflush  input  1  discard all currently visible FIFO contents
rclr_err  input  1  clear sticky underflow flag
raddr  output  ADDRSIZE  SRAM read address
rptr  output  ADDRSIZE+1  Gray read pointer to write domain
rempty  output  1  FIFO empty
ralmost_empty  output  1  occupancy <= AE_LEVEL
rcount  output  ADDRSIZE+1  visible occupancy, 0..2**ADDRSIZE
runderflow  output  1  sticky: read attempted while empty

Behaviour:
- Clock and reset: one clock, rclk. Reset rrst_n is synchronous and active-low. It is sampled only on rising rclk; no asynchronous reset path.
- Reset values:
  - rbin=0, rptr=0, raddr=0
  - rempty=1, ralmost_empty=1, rcount=0, runderflow=0
  - all synchronizer flops=0
- Reset asserted mid-operation: all of the above are forced on the next edge, regardless of other inputs.
- Synchronizer: an SYNC_STAGES-deep flop chain on wptr gives rq2_wptr. That value is converted combinationally Gray-to-binary to give rq2_wbin.
- Effective read: rd = rinc & ~rempty & ~rflush.
- Next pointer:
  - rbinnext = rflush ? rq2_wbin : rbin + rd
  - rgraynext = (rbinnext>>1) ^ rbinnext
  - Both are registered into rbin/rptr. raddr = rbin[ADDRSIZE-1:0].
- Occupancy: cnt_next = rq2_wbin - rbinnext, modulo 2**(ADDRSIZE+1). Registered each edge:
  - rcount <= cnt_next
  - rempty <= (rgraynext == rq2_wptr), which is equivalent to cnt_next==0
  - ralmost_empty <= (cnt_next <= AE_LEVEL)
- Latency:
  - rinc to updated flags: 1 cycle.
  - wptr change to flags: SYNC_STAGES+1 cycles.
  - Occupancy is conservative, never over-reports, because the write pointer is stale.
- Underflow:
  - Set when rinc & rempty & ~rflush; pointer unchanged.
  - Sticky until cleared. rclr_err clears it on the next edge.
  - Simultaneous set and clear: set wins.
- Flush:
  - rbin jumps to rq2_wbin on the next edge. rempty=1, rcount=0, ralmost_empty=1.
  - rflush with rinc: flush wins, rinc ignored, no underflow.
  - Words written but not yet synchronized stay readable afterwards.
- Wrap-around: pointers wrap modulo 2**(ADDRSIZE+1). raddr wraps 2**ADDRSIZE-1 to 0, and the rptr MSB toggles at each wrap. Full FIFO gives rcount=2**ADDRSIZE.
- Gray invariant: rptr changes by at most one bit per cycle except on flush. The write side must treat flush as a pointer jump; this is documented for integration.

Decomposition:
- Shared package fifo_pkg:
  - gray2bin and bin2gray functions
  - default ADDRSIZE
  - SYNC_STAGES minimum constant
- One sub-module: sync_w2r_n (parametrised ADDRSIZE+1 wide, SYNC_STAGES deep, synchronous active-low reset). The write domain reuses it.

Test Plan (ADDRSIZE=3, AE_LEVEL=2, SYNC_STAGES=2):
1. Reset/fill: rrst_n=0 for 3 cycles with wptr=gray(5)=0111 -> all reset values held. After release, 3 edges later: rcount=5, rempty=0, ralmost_empty=0.
2. Drain: wptr=gray(5) stable, rinc=1 for 5 cycles -> raddr 0,1,2,3,4 then 5. rcount 4,3,2,1,0; ralmost_empty=1 from rcount=2; rempty=1 after the 5th read; rptr=gray(5)=0111.
3. Underflow: rempty=1, rinc=1 one cycle -> rptr unchanged, runderflow=1 next edge and held. rclr_err pulse clears it; rclr_err with rinc while empty keeps it at 1.
4. Wrap: writer advances wptr through 20 words while reading continuously -> raddr wraps 7 to 0 twice, rptr MSB toggles at bin 8 and 16 (0 mod 16), rcount never exceeds 8, and rptr has single-bit changes only.
5. Flush: rcount=6, rflush=1 with rinc=1 -> next edge rbin=rq2_wbin, rempty=1, rcount=0, runderflow unchanged. A later wptr advance of 2 words gives rcount=2 after 3 cycles.
6. Mid-drain reset: rrst_n=0 for one cycle at rcount=3 -> next edge rptr=0, raddr=0, rempty=1, rcount=0, runderflow=0.
